// File: rtl/fulladder_sram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fulladder_sram                                             |
// | Description : Registered three-operand 2-bit adder (carry-save + ripple).|
// |               FULLADDER_SRAM_OUTREG_EN adds an output register stage.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fulladder_sram (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic [1:0] S,
  output logic       Cout
);

  // Operand store; names are kept so benches can probe dut.A/B/C.
  logic [1:0] A;
  logic [1:0] B;
  logic [1:0] C;

  logic [1:0] w_s;
  logic [1:0] w_k;
  logic [2:0] w_x;
  logic [2:0] w_y;
  logic [3:0] w_rc;
  logic [3:0] w_total;
  logic       w_cout;

  // 1-bit full adder cell: returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A <= 2'd0;
      B <= 2'd0;
      C <= 2'd0;
    end else begin
      A <= a;
      B <= b;
      C <= c;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_csa
    assign {w_k[i], w_s[i]} = fa(A[i], B[i], C[i]);
  end

  // Carry vector carries weight 2, so it enters the ripple stage shifted up.
  assign w_x     = {1'b0, w_s};
  assign w_y     = {w_k, 1'b0};
  assign w_rc[0] = 1'b0;

  for (genvar i = 0; i < 3; i++) begin : g_ripple
    assign {w_rc[i+1], w_total[i]} = fa(w_x[i], w_y[i], w_rc[i]);
  end

  assign w_total[3] = w_rc[3];
  assign w_cout     = w_total[3] | w_total[2];

`ifdef FULLADDER_SRAM_OUTREG_EN
  logic [1:0] r_s;
  logic       r_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= 2'd0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_total[1:0];
      r_cout <= w_cout;
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;
`else
  assign S    = w_total[1:0];
  assign Cout = w_cout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fulladder_sram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fulladder_sram                                          |
// | Description : Directed + random self-checking bench for fulladder_sram.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fulladder_sram;

`ifdef FULLADDER_SRAM_OUTREG_EN
  localparam int c_outreg = 1;
`else
  localparam int c_outreg = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a   = 2'd0;
  logic [1:0] b   = 2'd0;
  logic [1:0] c   = 2'd0;
  logic [1:0] S;
  logic       Cout;

  int n_cmp = 0;
  int n_err = 0;

  fulladder_sram dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .c    (c),
    .S    (S),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Apply a triple, check the store after one edge and the outputs after the
  // configured latency; inputs are held across the extra edge.
  task automatic apply(input string tag, input logic [1:0] ta, input logic [1:0] tb,
                       input logic [1:0] tc, input logic [1:0] es, input logic ec);
    a = ta; b = tb; c = tc;
    edge1();
    check({tag, ".store"}, {2'b0, dut.A, dut.B, dut.C} >> 2 == 4'd0 ? 4'd0 : 4'd0, 4'd0);
    check({tag, ".A"}, {2'b0, dut.A}, {2'b0, ta});
    check({tag, ".B"}, {2'b0, dut.B}, {2'b0, tb});
    check({tag, ".C"}, {2'b0, dut.C}, {2'b0, tc});
    if (c_outreg != 0) edge1();
    check({tag, ".S"},    {2'b0, S},    {2'b0, es});
    check({tag, ".Cout"}, {3'b0, Cout}, {3'b0, ec});
  endtask

  initial begin
    logic [1:0] ra, rb, rc;
    int         tot;
    logic [1:0] prev_s;
    logic       prev_c;

    // Reset held with operands toggling: nothing may load.
    #1;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 2'd3 : 2'd1;
      b = 2'd3;
      c = (i % 2 == 0) ? 2'd3 : 2'd2;
      edge1();
      check("rst.A",    {2'b0, dut.A}, 4'd0);
      check("rst.B",    {2'b0, dut.B}, 4'd0);
      check("rst.C",    {2'b0, dut.C}, 4'd0);
      check("rst.S",    {2'b0, S},     4'd0);
      check("rst.Cout", {3'b0, Cout},  4'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    a = 2'd3; b = 2'd3; c = 2'd3;
    #2;
    check("post_rst.S", {2'b0, S}, 4'd0);
    check("post_rst.A", {2'b0, dut.A}, 4'd0);

    apply("first_load", 2'd3, 2'd3, 2'd3, 2'd1, 1'b1);
    apply("no_ovf",     2'd1, 2'd1, 2'd1, 2'd3, 1'b0);
    apply("wrap",       2'd2, 2'd1, 2'd1, 2'd0, 1'b1);
    apply("zero",       2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    apply("max",        2'd3, 2'd3, 2'd3, 2'd1, 1'b1);
    apply("three",      2'd3, 2'd0, 2'd0, 2'd3, 1'b0);
    apply("six",        2'd2, 2'd2, 2'd2, 2'd2, 1'b1);
    apply("two",        2'd0, 2'd2, 2'd0, 2'd2, 1'b0);

    // Random stream, one triple per clock; registered-output build lags by one.
    prev_s = 2'd2;
    prev_c = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ra = 2'($urandom_range(3));
      rb = 2'($urandom_range(3));
      rc = 2'($urandom_range(3));
      a = ra; b = rb; c = rc;
      edge1();
      tot = int'(ra) + int'(rb) + int'(rc);
      check("rnd.A", {2'b0, dut.A}, {2'b0, ra});
      check("rnd.B", {2'b0, dut.B}, {2'b0, rb});
      check("rnd.C", {2'b0, dut.C}, {2'b0, rc});
      if (c_outreg != 0) begin
        check("rnd.S",    {2'b0, S},    {2'b0, prev_s});
        check("rnd.Cout", {3'b0, Cout}, {3'b0, prev_c});
      end else begin
        check("rnd.S",    {2'b0, S},    4'(tot % 4));
        check("rnd.Cout", {3'b0, Cout}, {3'b0, (tot > 3)});
      end
      prev_s = 2'(tot % 4);
      prev_c = (tot > 3);
    end

    // Outputs must ignore input changes between edges.
    a = 2'd3; b = 2'd3; c = 2'd3;
    edge1();
    if (c_outreg != 0) edge1();
    a = 2'd0; b = 2'd1; c = 2'd0;
    #3;
    check("hold.S",    {2'b0, S},    4'd1);
    check("hold.Cout", {3'b0, Cout}, 4'd1);

`ifdef FULLADDER_SRAM_OUTREG_EN
    a = 2'd2; b = 2'd2; c = 2'd0;
    edge1();
    check("lat.e1.S",    {2'b0, S},    4'd1);
    check("lat.e1.Cout", {3'b0, Cout}, 4'd1);
    edge1();
    check("lat.e2.S",    {2'b0, S},    4'd0);
    check("lat.e2.Cout", {3'b0, Cout}, 4'd1);
`endif

    // Mid-cycle async reset clears store and outputs without an edge.
    a = 2'd3; b = 2'd3; c = 2'd3;
    edge1();
    if (c_outreg != 0) edge1();
    check("pre_arst.Cout", {3'b0, Cout}, 4'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst.S",    {2'b0, S},     4'd0);
    check("arst.Cout", {3'b0, Cout},  4'd0);
    check("arst.A",    {2'b0, dut.A}, 4'd0);
    check("arst.C",    {2'b0, dut.C}, 4'd0);
    edge1();
    check("arst_hold.S", {2'b0, S}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fulladder_sram.md
# fulladder_sram

Registered three-operand 2-bit adder. Each clock it captures operands `a`, `b` and `c` into an internal operand store (registers `A`, `B`, `C`) and produces a 2-bit sum with an overflow carry from the stored values. It is a leaf arithmetic block for small-operand accumulation paths. The stored operands must remain hierarchically visible for debug and bench monitoring.

## Interface
Parameters:
- none. All widths are fixed at 2 bits.

Ports:
- `clk`  input  1  Rising-edge clock; the only clock.
- `rst`  input  1  Reset, asynchronous, active-high.
- `a`  input  2  Operand A, unsigned.
- `b`  input  2  Operand B, unsigned.
- `c`  input  2  Operand C, unsigned.
- `S`  output  2  Low 2 bits of A+B+C.
- `Cout`  output  1  High when A+B+C > 3.

Internal registers (must keep these exact names):
- `A`, `B`, `C`: 2-bit operand store, readable hierarchically as `dut.A`, `dut.B`, `dut.C`.

## Operation
- On every rising `clk` with `rst` low, load the operand store: A<=a, B<=b, C<=c.
- Compute total = A + B + C, unsigned, 4 bits wide, range 0..9.
- S = total[1:0].
- Cout = total[3] | total[2], meaning any overflow beyond 2 bits.
- Adder structure:
  - Stage 1: carry-save layer of two 1-bit full adders, one per bit over A, B, C. It produces sum vector s[1:0] and carry vector k[1:0].
  - Stage 2: 3-bit ripple add of {1'b0,s} + {k,1'b0}. Its bits [1:0] give S; Cout is the OR of its bits [3:2].
  - Full adders are a reusable 1-bit cell: sum = x^y^z, carry = majority(x,y,z).
- No enable input. The store updates every cycle.
- Operands are unsigned. There is no signed interpretation.

## Timing
- Reset:
  - Asserting `rst` immediately clears A, B, C, and any output register, to 0.
  - S=0 and Cout=0 while `rst` is high.
  - Outputs stay 0 until the first rising `clk` after `rst` deasserts.
- Default latency is 1 cycle. Inputs sampled at edge N appear on S/Cout after edge N, settling combinationally from the store.
- Inputs changing between edges have no effect on outputs.
- If `rst` asserts mid-cycle, outputs clear immediately, with no waiting for an edge.
- If `rst` deasserts coincident with a `clk` edge, that edge does not load. Loading starts at the next edge.

## Configuration
- `FULLADDER_SRAM_OUTREG_EN`:
  - Defined: S and Cout are driven from registers loaded at each rising `clk` from the combinational result of the store. Latency becomes 2 cycles. The output registers are async-reset to 0 by `rst`.
  - Undefined (default): S and Cout are combinational from A, B, C, with 1-cycle latency.
- The port list is identical in both builds.

## Test plan
- Reset: assert `rst` with a=3, b=3, c=3 toggling → S=0, Cout=0, A=B=C=0 throughout. Deassert → the next edge loads the operands.
- No overflow: a=1, b=1, c=1, one edge → A=1, B=1, C=1, S=3, Cout=0.
- Exact wrap: a=2, b=1, c=1 → S=0, Cout=1. Then a=0, b=0, c=0 → S=0, Cout=0.
- Maximum: a=3, b=3, c=3 → total 9, S=1, Cout=1. Then a=3, b=0, c=0 → S=3, Cout=0.
- Randomized: 20 random 2-bit triples, one per clock → after each edge, S == (A+B+C)%4 and Cout == ((A+B+C)>3), with A/B/C equal to the applied values.
- Latency: with `FULLADDER_SRAM_OUTREG_EN` defined, apply a=2, b=2, c=0 → S/Cout still hold the previous result after edge 1, and read S=0, Cout=1 after edge 2. A mid-test async `rst` clears them instantly.
